// File: rtl/vending_machine_gen2.sv
// Single-product vending controller: select, stock check, coin accumulation,
// vend with change, or refund on cancel/reselect/timeout. All outputs registered.
module vending_machine_gen2 #(
  parameter int unsigned               N_ITEMS     = 4,
  parameter int unsigned               CW          = 4,
  parameter logic [N_ITEMS*CW-1:0]     PRICES      = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int unsigned               TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_ITEMS-1:0]         sel,
  input  logic [N_ITEMS-1:0]         avail,
  input  logic                       c1,
  input  logic                       c2,
  input  logic                       cnl,
  output logic                       pdt,
  output logic [$clog2(N_ITEMS)-1:0] pdt_id,
  output logic [CW-1:0]              cng,
  output logic [CW-1:0]              rtn,
  output logic                       err,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(N_ITEMS);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    WAIT   = 3'd2,
    VEND   = 3'd3,
    REFUND = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pdt_q, pdt_d;
  logic [IW-1:0]   pdt_id_q, pdt_id_d;
  logic [CW-1:0]   cng_q, cng_d;
  logic [CW-1:0]   rtn_q, rtn_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   sel_idx;
  logic [CW-1:0]   price;
  logic [CW-1:0]   coin_val;
  logic [CW-1:0]   credit_new;
  logic            coin_ok;

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (sel[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    price = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (idx_q == IW'(i)) price = PRICES[i*CW +: CW];
    end
  end

  // Simultaneous c1 and c2 is rejected outright, so only a lone coin counts.
  always_comb begin
    coin_ok  = c1 ^ c2;
    coin_val = '0;
    if (c1 && !c2) coin_val = CW'(1);
    if (c2 && !c1) coin_val = CW'(2);
    credit_new = credit_q + coin_val;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    credit_d = credit_q;
    timer_d  = timer_q;
    pdt_d    = 1'b0;
    pdt_id_d = '0;
    cng_d    = '0;
    rtn_d    = '0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel != '0) begin
          if ($onehot(sel)) begin
            idx_d   = sel_idx;
            state_d = CHECK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CHECK: begin
        if (avail[idx_q]) begin
          credit_d = '0;
          timer_d  = '0;
          state_d  = WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        credit_d = credit_new;
        err_d    = c1 & c2;
        timer_d  = coin_ok ? '0 : timer_q + TW'(1);
        // Reaching the price wins over cancel/reselect/timeout in the same cycle.
        if (credit_new >= price) begin
          pdt_d    = 1'b1;
          pdt_id_d = idx_q;
          cng_d    = credit_new - price;
          state_d  = VEND;
        end else if (cnl || (sel != '0) ||
                     (!coin_ok && (timer_q == TW'(TIMEOUT_CYC - 1)))) begin
          rtn_d   = credit_new;
          state_d = REFUND;
        end
      end
      VEND: begin
        credit_d = '0;
        timer_d  = '0;
        state_d  = IDLE;
      end
      REFUND: begin
        credit_d = '0;
        timer_d  = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      credit_q <= '0;
      timer_q  <= '0;
      pdt_q    <= 1'b0;
      pdt_id_q <= '0;
      cng_q    <= '0;
      rtn_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
      timer_q  <= timer_d;
      pdt_q    <= pdt_d;
      pdt_id_q <= pdt_id_d;
      cng_q    <= cng_d;
      rtn_q    <= rtn_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign pdt    = pdt_q;
  assign pdt_id = pdt_id_q;
  assign cng    = cng_q;
  assign rtn    = rtn_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_vending_machine_gen2.sv
// Scenario bench for vending_machine_gen2 with default parameters
// (prices item0..3 = 3,4,5,6; timeout 16 idle cycles).
module tb_vending_machine_gen2;

  logic       clk;
  logic       rst;
  logic [3:0] sel;
  logic [3:0] avail;
  logic       c1;
  logic       c2;
  logic       cnl;
  logic       pdt;
  logic [1:0] pdt_id;
  logic [3:0] cng;
  logic [3:0] rtn;
  logic       err;
  logic       busy;

  int unsigned vectors;
  int unsigned miscompares;

  // Output word layout: {pdt, pdt_id[1:0], cng[3:0], rtn[3:0], err, busy}
  typedef struct packed {
    logic [3:0]  sel;
    logic [3:0]  avail;
    logic        c1;
    logic        c2;
    logic        cnl;
    logic [12:0] exp;
  } vec_t;

  logic [12:0] sb_q[$];

  vending_machine_gen2 #(
    .N_ITEMS    (4),
    .CW         (4),
    .PRICES     ({4'd6, 4'd5, 4'd4, 4'd3}),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .avail (avail),
    .c1    (c1),
    .c2    (c2),
    .cnl   (cnl),
    .pdt   (pdt),
    .pdt_id(pdt_id),
    .cng   (cng),
    .rtn   (rtn),
    .err   (err),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] outs();
    return {pdt, pdt_id, cng, rtn, err, busy};
  endfunction

  function automatic vec_t V(input logic [3:0] s, input logic [3:0] a,
                             input logic k1, input logic k2, input logic kc,
                             input logic p, input logic [1:0] id,
                             input logic [3:0] cg, input logic [3:0] rt,
                             input logic e, input logic b);
    vec_t v;
    v.sel = s; v.avail = a; v.c1 = k1; v.c2 = k2; v.cnl = kc;
    v.exp = {p, id, cg, rt, e, b};
    return v;
  endfunction

  // Shorthands: idle-with-busy and fully quiet expectations, all items stocked
  function automatic vec_t IB(input logic [3:0] s, input logic k1, input logic k2,
                              input logic kc);
    return V(s, 4'hF, k1, k2, kc, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1);
  endfunction

  function automatic vec_t Q0();
    return V(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endfunction

  task automatic drive(input vec_t v);
    sel = v.sel; avail = v.avail; c1 = v.c1; c2 = v.c2; cnl = v.cnl;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    #2;
    got = outs();
    vectors++;
    if (got !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %b required %b", got, 13'd0);
    end
    @(posedge clk); #1;
    got = outs();
    vectors++;
    if (got !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_held: got %b required %b", got, 13'd0);
    end
    rst = 1'b1;
  endtask

  task automatic test_vend();
    vec_t q[$];
    logic [12:0] e, got;
    q.push_back(IB(4'b0001, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 1, 0));
    q.push_back(V(4'b0000, 4'hF, 0, 1, 0, 1, 2'd0, 4'd1, 4'd0, 0, 1));
    q.push_back(Q0());
    foreach (q[i]) begin
      drive(q[i]); sb_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = outs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL vend[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_sold_out();
    vec_t q[$];
    logic [12:0] e, got;
    q.push_back(V(4'b0100, 4'b1011, 0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 0, 1));
    q.push_back(V(4'b0000, 4'b1011, 0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 1, 0));
    q.push_back(V(4'b0000, 4'b1011, 0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); sb_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = outs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL sold_out[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_cancel();
    vec_t q[$];
    logic [12:0] e, got;
    q.push_back(IB(4'b1000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 1, 0));
    q.push_back(IB(4'b0000, 1, 0, 0));
    q.push_back(V(4'b0000, 4'hF, 0, 0, 1, 0, 2'd0, 4'd0, 4'd3, 0, 1));
    q.push_back(Q0());
    // cancel with no credit: REFUND visible with rtn=0
    q.push_back(IB(4'b1000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 1));
    q.push_back(Q0());
    foreach (q[i]) begin
      drive(q[i]); sb_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = outs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL cancel[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t q[$];
    logic [12:0] e, got;
    q.push_back(IB(4'b0010, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 1, 0, 0));
    for (int k = 0; k < 10; k++) q.push_back(IB(4'b0000, 0, 0, 0));
    // double coin: err, no credit, and the idle timer keeps running
    q.push_back(V(4'b0000, 4'hF, 1, 1, 0, 0, 2'd0, 4'd0, 4'd0, 1, 1));
    for (int k = 0; k < 4; k++) q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(V(4'b0000, 4'hF, 0, 0, 0, 0, 2'd0, 4'd0, 4'd1, 0, 1));
    q.push_back(Q0());
    q.push_back(IB(4'b0010, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 1, 0, 0));
    q.push_back(V(4'b0000, 4'hF, 1, 1, 0, 0, 2'd0, 4'd0, 4'd0, 1, 1));
    q.push_back(IB(4'b0000, 1, 0, 0));
    q.push_back(IB(4'b0000, 1, 0, 0));
    q.push_back(V(4'b0000, 4'hF, 1, 0, 0, 1, 2'd1, 4'd0, 4'd0, 0, 1));
    q.push_back(Q0());
    foreach (q[i]) begin
      drive(q[i]); sb_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = outs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_invalid_sel();
    vec_t q[$];
    logic [12:0] e, got;
    q.push_back(V(4'b0011, 4'hF, 0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 1, 0));
    q.push_back(Q0());
    q.push_back(V(4'b1111, 4'hF, 0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 1, 0));
    q.push_back(V(4'b0000, 4'hF, 1, 0, 0, 0, 2'd0, 4'd0, 4'd0, 0, 0));
    q.push_back(V(4'b0000, 4'hF, 0, 0, 1, 0, 2'd0, 4'd0, 4'd0, 0, 0));
    q.push_back(IB(4'b1000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 1, 0));
    q.push_back(V(4'b0000, 4'hF, 0, 1, 1, 0, 2'd0, 4'd0, 4'd4, 0, 1));
    q.push_back(Q0());
    foreach (q[i]) begin
      drive(q[i]); sb_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = outs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL invalid_sel[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_priority();
    vec_t q[$];
    logic [12:0] e, got;
    q.push_back(IB(4'b0001, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 1, 0));
    q.push_back(V(4'b0000, 4'hF, 0, 1, 1, 1, 2'd0, 4'd1, 4'd0, 0, 1));
    q.push_back(Q0());
    q.push_back(IB(4'b0001, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 1, 0, 0));
    q.push_back(V(4'b0100, 4'hF, 0, 0, 0, 0, 2'd0, 4'd0, 4'd1, 0, 1));
    q.push_back(Q0());
    foreach (q[i]) begin
      drive(q[i]); sb_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = outs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL priority[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t q[$];
    vec_t r[$];
    logic [12:0] e, got;
    q.push_back(IB(4'b1000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 1, 0));
    q.push_back(IB(4'b0000, 1, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); sb_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = outs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset_mid_pre[%0d]: got %b required %b", i, got, e);
      end
    end
    drive(Q0());
    rst = 1'b0;
    #1;
    got = outs(); vectors++;
    if (got !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got %b required %b", got, 13'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    r.push_back(Q0());
    r.push_back(IB(4'b0001, 0, 0, 0));
    r.push_back(IB(4'b0000, 0, 0, 0));
    r.push_back(IB(4'b0000, 0, 0, 1));
    r.push_back(Q0());
    foreach (r[i]) begin
      drive(r[i]); sb_q.push_back(r[i].exp);
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = outs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset_mid_post[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t q[$];
    logic [12:0] e, got;
    q.push_back(IB(4'b0010, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 1, 0));
    q.push_back(V(4'b0000, 4'hF, 0, 1, 0, 1, 2'd1, 4'd0, 4'd0, 0, 1));
    q.push_back(V(4'b0010, 4'hF, 0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 0, 0));
    q.push_back(IB(4'b0100, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 1, 0));
    q.push_back(IB(4'b0000, 0, 1, 0));
    q.push_back(V(4'b0000, 4'hF, 0, 1, 0, 1, 2'd2, 4'd1, 4'd0, 0, 1));
    q.push_back(Q0());
    q.push_back(IB(4'b1000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 0, 0));
    q.push_back(IB(4'b0000, 0, 1, 0));
    q.push_back(IB(4'b0000, 0, 1, 0));
    q.push_back(V(4'b0000, 4'hF, 0, 1, 0, 1, 2'd3, 4'd0, 4'd0, 0, 1));
    q.push_back(Q0());
    foreach (q[i]) begin
      drive(q[i]); sb_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = sb_q.pop_front(); got = outs(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b0;
    sel   = '0;
    avail = 4'hF;
    c1    = 1'b0;
    c2    = 1'b0;
    cnl   = 1'b0;
    test_reset();
    test_vend();
    test_sold_out();
    test_cancel();
    test_timeout();
    test_invalid_sel();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vending_machine_gen2.md
VENDING_MACHINE_GEN2 -- requirements
Module: vending_machine_gen2

Interface
REQ-001 Parameter N_ITEMS, default 4: number of selectable items, range 2..16.
REQ-002 Parameter CW, default 4: credit, change and refund width in bits.
REQ-003 Parameter PRICES, default {4'd6,4'd5,4'd4,4'd3}: packed N_ITEMS*CW price list; item i price = PRICES[i*CW +: CW]; every price SHALL be 1..2^CW-3.
REQ-004 Parameter TIMEOUT_CYC, default 16: idle cycles in WAIT before automatic refund; minimum 2.
REQ-005 clk  input  1  single clock; all state changes on posedge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 sel  input  N_ITEMS  item select request; must be one-hot to be valid.
REQ-008 avail  input  N_ITEMS  per-item stock flag; 1 = in stock.
REQ-009 c1  input  1  coin of value 1, sampled once per cycle.
REQ-010 c2  input  1  coin of value 2, sampled once per cycle.
REQ-011 cnl  input  1  cancel request.
REQ-012 pdt  output  1  product released, one-cycle pulse.
REQ-013 pdt_id  output  $clog2(N_ITEMS)  index of released item, valid while pdt=1, else 0.
REQ-014 cng  output  CW  change owed, valid while pdt=1, else 0.
REQ-015 rtn  output  CW  refunded credit, valid for one cycle in REFUND, else 0.
REQ-016 err  output  1  one-cycle pulse on invalid select, sold-out, or double coin.
REQ-017 busy  output  1  1 whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, CHECK, WAIT, VEND, REFUND; all outputs registered.
REQ-019 IDLE: one-hot sel -> latch index idx, go to CHECK; nonzero non-one-hot sel -> err=1 for one cycle, stay IDLE; sel=0 -> stay.
REQ-020 CHECK: avail[idx]=1 -> go to WAIT with credit=0 and timer=0; avail[idx]=0 -> err=1 for one cycle, go to IDLE.
REQ-021 WAIT coin rules: c1 alone adds 1; c2 alone adds 2; c1&c2 in the same cycle adds nothing, pulses err and does not reset the timer.
REQ-022 WAIT: at the edge where credit plus the accepted coin >= PRICE(idx), go to VEND; pdt=1, pdt_id=idx, cng=credit_new-PRICE(idx) for exactly that cycle.
REQ-023 WAIT: cnl=1, or any nonzero sel, -> go to REFUND; a coin accepted in the same cycle is included in rtn.
REQ-024 Completion of price (REQ-022) SHALL take priority over cnl/sel in the same cycle.
REQ-025 WAIT timer increments each cycle without an accepted coin and clears on each accepted coin; at TIMEOUT_CYC-1 -> REFUND.
REQ-026 REFUND: rtn=credit for one cycle (0 if no coins), then IDLE.
REQ-027 VEND: after one cycle -> IDLE; credit cleared.
REQ-028 Credit arithmetic is CW-bit unsigned; REQ-003 bounds guarantee no overflow.
REQ-029 Latency: sel edge k -> CHECK at k+1 -> WAIT at k+2; final coin edge m -> pdt high from m to m+1.
REQ-030 c1/c2/cnl outside WAIT are ignored.

Reset
REQ-031 rst=0 SHALL force state IDLE, credit=0, timer=0, and pdt, pdt_id, cng, rtn, err, busy all 0, immediately and independent of clk.
REQ-032 Reset mid-operation discards credit with no rtn pulse; operation resumes at the first posedge after rst=1.

Verification
REQ-033 sel=0001, c2, c2 -> pdt=1, pdt_id=0, cng=1 for one cycle, then busy=0.
REQ-034 sel=0100 with avail=1011 -> err pulse 2 cycles after sel, pdt never 1, returns to IDLE.
REQ-035 sel=1000, c2, c1, cnl -> rtn=3 for one cycle, pdt=0, cng=0.
REQ-036 sel=0010, c1, then 16 cycles of no input -> rtn=1 on timeout; c1&c2 in WAIT -> err pulse, credit unchanged.
REQ-037 IDLE sel=0011 -> err pulse, stays IDLE; WAIT with credit 2 (item3), c2 and cnl in the same cycle -> rtn=4.
REQ-038 rst=0 while in WAIT with credit=3 -> all outputs 0 asynchronously, no rtn pulse, IDLE after release.
